// File: rtl/fas_pkg.sv
// fas_pkg: shared constants and types for the frequency analyzer.
//   NBINS   bins per FFT frame (16 only)
//   DW      width of each signed real/imag part (Q8.8)
//   MAG_W   width of a squared magnitude (unsigned)
//   mag_t   squared-magnitude type
//   state_t scan engine states
package fas_pkg;

   localparam int unsigned NBINS = 16;
   localparam int unsigned DW    = 16;
   localparam int unsigned MAG_W = 32;

   typedef logic [MAG_W-1:0] mag_t;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

endpackage

// File: rtl/cmag_sq.sv
// cmag_sq: combinational squared magnitude re*re + im*im of one complex bin.
//   i_re    signed real part, DW bits
//   i_im    signed imaginary part, DW bits
//   o_mag_c unsigned squared magnitude, MAG_W bits (combinational)
module cmag_sq import fas_pkg::*; #(
   parameter int unsigned DW = fas_pkg::DW
) (
   input  logic signed [DW-1:0] i_re,
   input  logic signed [DW-1:0] i_im,
   output mag_t                 o_mag_c
);

   localparam int unsigned PW = 2 * DW;

   logic signed [PW-1:0] w_re_sq;
   logic signed [PW-1:0] w_im_sq;

   // Sign-extend before multiplying so (-2^(DW-1))^2 is exact.
   assign w_re_sq = PW'(i_re) * PW'(i_re);
   assign w_im_sq = PW'(i_im) * PW'(i_im);

   // Each square is at most 2^(2*DW-2), so the sum stays below 2^(2*DW-1)+1.
   assign o_mag_c = MAG_W'($unsigned(w_re_sq)) + MAG_W'($unsigned(w_im_sq));

endmodule

// File: rtl/freq_analyzer.sv
// freq_analyzer: finds the bin with the largest magnitude in each FFT frame.
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   fft_valid    a frame is present on fft_d0..fft_d15
//   fft_d0..15   bin k: real in [2*DW-1:DW], imaginary in [DW-1:0]
//   done         one-cycle pulse, freq valid for a new frame
//   freq         index of the largest-magnitude bin, held until next done
//   overrun      sticky, a frame arrived while the input FIFO was full
// Frames enter a 2-deep FIFO; the scan engine pops one frame and examines
// one bin per cycle, reloading on the last bin so back-to-back frames run
// at one frame per 16 cycles.
module freq_analyzer import fas_pkg::*; #(
   parameter int unsigned NBINS = fas_pkg::NBINS,
   parameter int unsigned DW    = fas_pkg::DW
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     fft_valid,
   input  logic [2*DW-1:0]          fft_d0,
   input  logic [2*DW-1:0]          fft_d1,
   input  logic [2*DW-1:0]          fft_d2,
   input  logic [2*DW-1:0]          fft_d3,
   input  logic [2*DW-1:0]          fft_d4,
   input  logic [2*DW-1:0]          fft_d5,
   input  logic [2*DW-1:0]          fft_d6,
   input  logic [2*DW-1:0]          fft_d7,
   input  logic [2*DW-1:0]          fft_d8,
   input  logic [2*DW-1:0]          fft_d9,
   input  logic [2*DW-1:0]          fft_d10,
   input  logic [2*DW-1:0]          fft_d11,
   input  logic [2*DW-1:0]          fft_d12,
   input  logic [2*DW-1:0]          fft_d13,
   input  logic [2*DW-1:0]          fft_d14,
   input  logic [2*DW-1:0]          fft_d15,
   output logic                     done,
   output logic [$clog2(NBINS)-1:0] freq,
   output logic                     overrun
);

   localparam int unsigned IDX_W = $clog2(NBINS);
   localparam int unsigned EW    = 2 * DW;
   localparam int unsigned DEPTH = 2;

   // Input bins gathered into an array.
   logic [EW-1:0] w_din [NBINS];

   assign w_din[0]  = fft_d0;
   assign w_din[1]  = fft_d1;
   assign w_din[2]  = fft_d2;
   assign w_din[3]  = fft_d3;
   assign w_din[4]  = fft_d4;
   assign w_din[5]  = fft_d5;
   assign w_din[6]  = fft_d6;
   assign w_din[7]  = fft_d7;
   assign w_din[8]  = fft_d8;
   assign w_din[9]  = fft_d9;
   assign w_din[10] = fft_d10;
   assign w_din[11] = fft_d11;
   assign w_din[12] = fft_d12;
   assign w_din[13] = fft_d13;
   assign w_din[14] = fft_d14;
   assign w_din[15] = fft_d15;

   // Frame FIFO storage and bookkeeping.
   logic [EW-1:0] r_fifo [DEPTH][NBINS];
   logic          r_wr_ptr;
   logic          r_rd_ptr;
   logic [1:0]    r_count;

   // Working frame and scan state.
   logic [EW-1:0]    r_work [NBINS];
   state_t           r_state;
   state_t           w_state_nxt;
   logic [IDX_W-1:0] r_bin;
   logic [IDX_W-1:0] r_idx;
   mag_t             r_max;
   logic             r_done;
   logic [IDX_W-1:0] r_freq;
   logic             r_overrun;

   logic          w_pop;
   logic          w_push;
   logic          w_last;
   logic          w_full;
   logic          w_gt;
   logic [EW-1:0] w_cur;
   mag_t          w_mag;

   assign w_full = (r_count == 2'(DEPTH));
   // A pop on the same edge frees a slot, so a full FIFO still accepts.
   assign w_push = fft_valid && (!w_full || w_pop);

   assign w_cur = r_work[r_bin];

   cmag_sq #(
      .DW (DW)
   ) u_cmag (
      .i_re    (w_cur[EW-1:DW]),
      .i_im    (w_cur[DW-1:0]),
      .o_mag_c (w_mag)
   );

   // Strict compare keeps the lowest index on ties.
   assign w_gt = (w_mag > r_max);

   // Next-state and pop control for the scan engine.
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_count != 2'd0) begin
               w_pop       = 1'b1;
               w_state_nxt = SCAN;
            end
         end
         SCAN: begin
            if (r_bin == IDX_W'(NBINS - 1)) begin
               w_last = 1'b1;
               if (r_count != 2'd0) begin
                  w_pop = 1'b1;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_count <= r_count + 2'(w_push) - 2'(w_pop);
      end
   end

   // FIFO data; on a full push+pop the slot written is the one being read,
   // which is safe because the pop samples the pre-edge contents.
   always_ff @(posedge clk) begin
      if (w_push) begin
         for (int k = 0; k < NBINS; k++) begin
            r_fifo[r_wr_ptr][k] <= w_din[k];
         end
      end
   end

   // Working frame load on pop.
   always_ff @(posedge clk) begin
      if (w_pop) begin
         for (int k = 0; k < NBINS; k++) begin
            r_work[k] <= r_fifo[r_rd_ptr][k];
         end
      end
   end

   // Running maximum, bin counter and result registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_bin     <= '0;
         r_idx     <= '0;
         r_max     <= '0;
         r_done    <= 1'b0;
         r_freq    <= '0;
         r_overrun <= 1'b0;
      end else begin
         if (r_state == SCAN) begin
            if (w_gt) begin
               r_max <= w_mag;
               r_idx <= r_bin;
            end
            r_bin <= r_bin + IDX_W'(1);
         end
         // A reload restarts the search for the next frame.
         if (w_pop) begin
            r_bin <= '0;
            r_idx <= '0;
            r_max <= '0;
         end
         r_done <= w_last;
         if (w_last) begin
            r_freq <= w_gt ? r_bin : r_idx;
         end
         if (fft_valid && !w_push) begin
            r_overrun <= 1'b1;
         end
      end
   end

   assign done    = r_done;
   assign freq    = r_freq;
   assign overrun = r_overrun;

endmodule

// File: tb/tb_freq_analyzer.sv
// tb_freq_analyzer: scoreboard bench for freq_analyzer.
// The stimulus side predicts, per frame, whether it is accepted, the edge
// its done pulse lands on and the peak bin; a monitor checks every done.
module tb_freq_analyzer;

   typedef logic [31:0] frame_t [16];

   typedef struct {
      int         ed;
      logic [3:0] f;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        fft_valid;
   logic [31:0] d [16];
   logic        done;
   logic [3:0]  freq;
   logic        overrun;

   int   n_vec = 0;
   int   n_err = 0;
   int   edge_cnt = 0;
   exp_t exp_q [$];
   int   starts [$];
   int   last_start = -1000;
   int   last_accept_start = 0;
   int   ovr_edge = -1;

   freq_analyzer dut (
      .clk       (clk),
      .rst       (rst),
      .fft_valid (fft_valid),
      .fft_d0    (d[0]),
      .fft_d1    (d[1]),
      .fft_d2    (d[2]),
      .fft_d3    (d[3]),
      .fft_d4    (d[4]),
      .fft_d5    (d[5]),
      .fft_d6    (d[6]),
      .fft_d7    (d[7]),
      .fft_d8    (d[8]),
      .fft_d9    (d[9]),
      .fft_d10   (d[10]),
      .fft_d11   (d[11]),
      .fft_d12   (d[12]),
      .fft_d13   (d[13]),
      .fft_d14   (d[14]),
      .fft_d15   (d[15]),
      .done      (done),
      .freq      (freq),
      .overrun   (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string nm, input longint act, input longint expv);
      n_vec++;
      if (act != expv) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (edge %0d)", nm, act, expv, edge_cnt);
      end
   endtask

   // Reference: largest re^2+im^2, first index wins on ties.
   function automatic logic [3:0] ref_peak(input frame_t f);
      longint best = 0;
      int     idx = 0;
      longint re;
      longint im;
      longint m;
      for (int k = 0; k < 16; k++) begin
         re = longint'($signed(f[k][31:16]));
         im = longint'($signed(f[k][15:0]));
         m  = re * re + im * im;
         if (m > best) begin
            best = m;
            idx  = k;
         end
      end
      return 4'(idx);
   endfunction

   function automatic logic exp_ovr();
      return (ovr_edge >= 0) && (edge_cnt >= ovr_edge);
   endfunction

   function automatic logic [15:0] rnd_part();
      case ($urandom_range(0, 5))
         0:       return 16'h0000;
         1:       return 16'h0100;
         2:       return 16'hFF00;
         3:       return 16'h8000;
         4:       return 16'h7FFF;
         default: return 16'($urandom);
      endcase
   endfunction

   // Frame occupancy model: the engine needs 16 edges per frame and may take
   // the next one on the edge it finishes; at most two frames wait.
   task automatic send(input frame_t f);
      int t;
      int pending;
      int st;
      @(negedge clk);
      for (int k = 0; k < 16; k++) d[k] = f[k];
      fft_valid = 1'b1;
      t = edge_cnt + 1;
      while (starts.size() > 0 && starts[0] <= t) void'(starts.pop_front());
      pending = starts.size();
      if (pending < 2) begin
         st = (t + 1 > last_start + 16) ? t + 1 : last_start + 16;
         last_start = st;
         last_accept_start = st;
         starts.push_back(st);
         exp_q.push_back('{ed: st + 16, f: ref_peak(f)});
      end else if (ovr_edge < 0) begin
         ovr_edge = t;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         fft_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int n = 0;
      idle(1);
      while (exp_q.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("drain_pending", exp_q.size(), 0);
      idle(2);
   endtask

   // Monitor: every done must match the head of the scoreboard.
   initial begin
      exp_t       e;
      logic [3:0] last_freq = 4'd0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            last_freq = 4'd0;
         end else begin
            if (done) begin
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected_done: got done=1 freq=%0d, expected no done (edge %0d)", freq, edge_cnt);
               end else begin
                  e = exp_q.pop_front();
                  chk("done_edge", edge_cnt, e.ed);
                  chk("freq", freq, e.f);
                  chk("overrun_at_done", overrun, exp_ovr());
               end
            end else if (freq != last_freq) begin
               n_vec++;
               n_err++;
               $display("FAIL freq_without_done: got %0d, expected %0d (edge %0d)", freq, last_freq, edge_cnt);
            end
            last_freq = freq;
         end
      end
   end

   initial begin
      frame_t f;
      int     p;
      rst = 1'b0;
      fft_valid = 1'b0;
      for (int k = 0; k < 16; k++) d[k] = 32'h0;
      repeat (3) @(negedge clk);
      chk("reset_done", done, 0);
      chk("reset_freq", freq, 0);
      chk("reset_overrun", overrun, 0);
      rst = 1'b1;

      // Single peak at bin 3.
      for (int k = 0; k < 16; k++) f[k] = 32'h0;
      f[3] = 32'h0200_0000;
      send(f);
      drain();

      // Tie between bins 2 and 14.
      for (int k = 0; k < 16; k++) f[k] = 32'h0010_0010;
      f[2]  = 32'h0100_FF00;
      f[14] = 32'h0100_FF00;
      send(f);
      drain();

      // Largest possible magnitude in bin 15.
      for (int k = 0; k < 16; k++) f[k] = 32'h7FFF_0000;
      f[15] = 32'h8000_8000;
      send(f);
      drain();

      // All-zero frame.
      for (int k = 0; k < 16; k++) f[k] = 32'h0;
      send(f);
      drain();

      // 64 frames at full rate, peaks alternating 1 / 15.
      for (int i = 0; i < 64; i++) begin
         for (int k = 0; k < 16; k++) f[k] = {8'($urandom_range(0, 255)) & 16'h00FF, 16'($urandom_range(0, 255))};
         p = (i % 2 == 0) ? 1 : 15;
         f[p] = 32'h0400_0000;
         send(f);
         if (i != 63) idle(15);
      end
      drain();
      chk("overrun_after_stream", overrun, 0);

      // Four back-to-back frames: the fourth is dropped.
      for (int i = 0; i < 4; i++) begin
         for (int k = 0; k < 16; k++) f[k] = 32'h0001_0001;
         f[4 + i] = 32'h0300_0000;
         send(f);
      end
      drain();
      chk("overrun_after_burst", overrun, 1);
      idle(5);
      chk("overrun_sticky", overrun, 1);

      // Reset in the middle of a scan.
      for (int k = 0; k < 16; k++) f[k] = 32'h0;
      f[9] = 32'h0500_0000;
      send(f);
      idle(1);
      while (edge_cnt < last_accept_start + 8) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("midscan_rst_done", done, 0);
      chk("midscan_rst_freq", freq, 0);
      chk("midscan_rst_overrun", overrun, 0);
      @(negedge clk);
      exp_q.delete();
      starts.delete();
      last_start = -1000;
      ovr_edge = -1;
      rst = 1'b1;

      // Frame right after reset release.
      for (int k = 0; k < 16; k++) f[k] = 32'h0;
      f[6] = 32'h0000_0300;
      send(f);
      drain();

      // Random frames with random spacing, including drops.
      for (int i = 0; i < 80; i++) begin
         for (int k = 0; k < 16; k++) f[k] = {rnd_part(), rnd_part()};
         send(f);
         idle($urandom_range(0, 20));
      end
      drain();
      chk("overrun_final", overrun, exp_ovr());

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
